// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame states and oversampling constants
// Shared by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - show-ahead receive FIFO with occupancy count and overrun pulse
// Push and pop in the same cycle both take effect, including when full.
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge sclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled 8N1 UART receiver feeding rx_fifo
// Define UART_RX_PARITY_EN for 8 data + parity + stop framing.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic [15:0]            div,
  input  logic                   read,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err
);

  localparam logic [3:0] MID_CNT  = 4'(MID_TICK);
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic       rx_meta;
  logic       rx_s;
  logic       rx_prev;
  logic [15:0] tick_cnt;
  logic       tick;
  rx_state_t  state;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       start_edge;
  logic       stop_sample;
  logic       par_ok;
  logic       push;

  always_ff @(posedge sclk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_s;

  // Restarting the tick phase at the start edge centres every later sample in its bit.
  always_ff @(posedge sclk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (start_edge || tick_cnt >= div) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign tick        = (tick_cnt == div);
  assign stop_sample = (state == STOP) && tick && (os_cnt == LAST_CNT);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_err_q;
  assign par_ok     = (((^shreg) ^ par_bit) == PARITY_ODD[0]);
  assign parity_err = parity_err_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

  assign push = stop_sample && rx_s && par_ok;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= stop_sample && rx_s && !par_ok;
`endif
      case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == MID_CNT) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == LAST_CNT) begin
              os_cnt  <= '0;
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (os_cnt == LAST_CNT) begin
              os_cnt  <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          // Leaving at mid-stop lets a start edge in the stop bit's second half be seen.
          if (tick) begin
            if (os_cnt == LAST_CNT) begin
              os_cnt <= '0;
              state  <= IDLE;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .sclk    (sclk),
    .rst     (rst),
    .push    (push),
    .wdata   (shreg),
    .pop     (read),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
// Byte queue model fed from the frames the bench serialises.
module tb_uart_receiver;

  localparam int DEPTH      = 16;
  localparam int PARITY_ODD = 0;
  localparam int CW         = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          sclk = 1'b0;
  logic          rst  = 1'b1;
  logic          rx   = 1'b1;
  logic          read = 1'b0;
  logic [15:0]   div  = 16'd1;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  int errors = 0;
  int checks = 0;
  int n_frame = 0, n_ovr = 0, n_par = 0;
  int exp_frame = 0, exp_ovr = 0, exp_par = 0;
  logic [7:0] q[$];

  uart_receiver #(
    .DEPTH(DEPTH),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .rx         (rx),
    .div        (div),
    .read       (read),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (frame_err === 1'b1) n_frame++;
    if (overrun === 1'b1) n_ovr++;
    if (parity_err === 1'b1) n_par++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic hold_bits(input int n);
    repeat (n * 16 * (int'(div) + 1)) @(negedge sclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    q.delete();
  endtask

  // Serialises one frame and updates the model with what the receiver should do with it.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ (PARITY_ODD != 0) ^ bad_par;
    hold_bits(1);
`endif
    rx = stop_bit;
    hold_bits(1);
    rx = 1'b1;
    if (!stop_bit) exp_frame++;
    else if (PAR_EN && bad_par) exp_par++;
    else if (q.size() < DEPTH) q.push_back(d);
    else exp_ovr++;
  endtask

  task automatic pop_byte(output logic [7:0] got, output logic was_empty);
    got       = dout;
    was_empty = empty;
    read = 1'b1;
    @(negedge sclk);
    read = 1'b0;
  endtask

  task automatic test_reset();
    div = 16'd1;
    do_reset();
    checks++;
    if ({empty, full, count, dout} !== {1'b1, 1'b0, CW'(0), 8'h00}) begin
      errors++;
      $display("FAIL reset_status: empty=%b full=%b count=%0d dout=%h, want 1 0 0 00", empty, full, count, dout);
    end
    checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: frame_err/overrun/parity_err=%b%b%b, want 000", frame_err, overrun, parity_err);
    end
  endtask

  task automatic test_basic();
    logic [7:0] got;
    logic       was_e;
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge sclk);
    checks++;
    if (count !== CW'(q.size()) || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: count=%0d empty=%b, want count=%0d empty=0", count, empty, q.size());
    end
    for (int i = 0; i < 2; i++) begin
      pop_byte(got, was_e);
      checks++;
      if (was_e !== 1'b0 || got !== q[0]) begin
        errors++;
        $display("FAIL basic_read%0d: dout=%h empty=%b, want dout=%h empty=0", i, got, was_e, q[0]);
      end
      void'(q.pop_front());
    end
    checks++;
    if (empty !== 1'b1 || count !== CW'(0)) begin
      errors++;
      $display("FAIL basic_drained: empty=%b count=%0d, want 1 0", empty, count);
    end
    checks++;
    if (n_frame !== exp_frame || n_ovr !== exp_ovr || n_par !== exp_par) begin
      errors++;
      $display("FAIL basic_pulses: got %0d/%0d/%0d, want %0d/%0d/%0d", n_frame, n_ovr, n_par, exp_frame, exp_ovr, exp_par);
    end
  endtask

  task automatic test_false_start();
    logic [7:0] got;
    logic       was_e;
    rx = 1'b0;
    repeat (4 * (int'(div) + 1)) @(negedge sclk);
    rx = 1'b1;
    hold_bits(12);
    checks++;
    if (empty !== 1'b1 || count !== CW'(0) || n_frame !== exp_frame) begin
      errors++;
      $display("FAIL false_start: empty=%b count=%0d frame_errs=%0d, want 1 0 %0d", empty, count, n_frame, exp_frame);
    end
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (2) @(negedge sclk);
    pop_byte(got, was_e);
    checks++;
    if (was_e !== 1'b0 || got !== q[0]) begin
      errors++;
      $display("FAIL false_start_recover: dout=%h empty=%b, want dout=%h empty=0", got, was_e, q[0]);
    end
    void'(q.pop_front());
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b0);
    hold_bits(1);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h55, 1'b0, 1'b1);
    hold_bits(1);
`endif
    checks++;
    if (count !== CW'(0) || empty !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_count: count=%0d empty=%b, want 0 1", count, empty);
    end
    checks++;
    if (n_frame !== exp_frame || n_par !== exp_par) begin
      errors++;
      $display("FAIL frame_err_pulses: frame_err=%0d parity_err=%0d, want %0d %0d", n_frame, n_par, exp_frame, exp_par);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    logic       was_e;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (2) @(negedge sclk);
    checks++;
    if (full !== 1'b1 || count !== CW'(DEPTH) || empty !== 1'b0) begin
      errors++;
      $display("FAIL overrun_full: full=%b count=%0d empty=%b, want 1 %0d 0", full, count, empty, DEPTH);
    end
    checks++;
    if (n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL overrun_pulse: overruns=%0d, want %0d", n_ovr, exp_ovr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte(got, was_e);
      checks++;
      if (was_e !== 1'b0 || got !== q[0]) begin
        errors++;
        $display("FAIL overrun_read%0d: dout=%h empty=%b, want dout=%h empty=0", i, got, was_e, q[0]);
      end
      void'(q.pop_front());
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drained: empty=%b full=%b, want 1 0", empty, full);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] got;
    logic       was_e;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (2) @(negedge sclk);
    checks++;
    if (n_par !== exp_par || count !== CW'(q.size())) begin
      errors++;
      $display("FAIL parity_drop: parity_errs=%0d count=%0d, want %0d %0d", n_par, count, exp_par, q.size());
    end
    pop_byte(got, was_e);
    checks++;
    if (was_e !== 1'b0 || got !== q[0]) begin
      errors++;
      $display("FAIL parity_accept: dout=%h empty=%b, want dout=%h empty=0", got, was_e, q[0]);
    end
    void'(q.pop_front());
  endtask
`endif

  task automatic test_reset_mid();
    send_frame(8'h5A, 1'b1, 1'b0);
    rx = 1'b0;
    hold_bits(1);
    rx = 1'b1;
    hold_bits(1);
    rx = 1'b0;
    repeat (8 * (int'(div) + 1)) @(negedge sclk);
    do_reset();
    hold_bits(12);
    checks++;
    if (empty !== 1'b1 || count !== CW'(0)) begin
      errors++;
      $display("FAIL reset_mid_fifo: empty=%b count=%0d, want 1 0", empty, count);
    end
    checks++;
    if (n_frame !== exp_frame || n_ovr !== exp_ovr || n_par !== exp_par) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d/%0d/%0d, want %0d/%0d/%0d", n_frame, n_ovr, n_par, exp_frame, exp_ovr, exp_par);
    end
  endtask

  task automatic test_random();
    logic [7:0] got;
    logic [7:0] exp_b;
    logic       was_e;
    logic       stop_b;
    for (int r = 0; r < 3; r++) begin
      div = 16'($urandom_range(0, 3));
      do_reset();
      for (int k = 0; k < 8; k++) begin
        stop_b = ($urandom_range(0, 7) != 0);
        send_frame(8'($urandom), stop_b, 1'($urandom_range(0, 5) == 0));
        if (!stop_b) hold_bits(1);
        repeat (2) @(negedge sclk);
        for (int p = $urandom_range(0, 2); p > 0; p--) begin
          pop_byte(got, was_e);
          checks++;
          if (q.size() == 0) begin
            if (was_e !== 1'b1) begin
              errors++;
              $display("FAIL rand_empty r%0d k%0d: empty=%b, want 1", r, k, was_e);
            end
          end else begin
            exp_b = q.pop_front();
            if (was_e !== 1'b0 || got !== exp_b) begin
              errors++;
              $display("FAIL rand_read r%0d k%0d: dout=%h empty=%b, want dout=%h empty=0", r, k, got, was_e, exp_b);
            end
          end
        end
        checks++;
        if (count !== CW'(q.size()) || empty !== (q.size() == 0)) begin
          errors++;
          $display("FAIL rand_count r%0d k%0d: count=%0d empty=%b, want count=%0d", r, k, count, empty, q.size());
        end
      end
      checks++;
      if (n_frame !== exp_frame || n_ovr !== exp_ovr || n_par !== exp_par) begin
        errors++;
        $display("FAIL rand_pulses r%0d: got %0d/%0d/%0d, want %0d/%0d/%0d", r, n_frame, n_ovr, n_par, exp_frame, exp_ovr, exp_par);
      end
    end
  endtask

  initial begin
    @(negedge sclk);
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
